// File: rtl/avst_pkt_sink.sv
// rtl/avst_pkt_sink.sv - Avalon-ST packet sink with framing checks, beat checksum and statistics
module avst_pkt_sink #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    output logic               pkt_done,
    output logic [15:0]        pkt_len,
    output logic [DATA_W-1:0]  pkt_xsum,
    output logic               pkt_err,
    output logic [2:0]         err_code,
    output logic [CNT_W-1:0]   pkt_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   byte_count
);
    localparam int LEN_W = 17;
    localparam int BPB   = DATA_W / 8;
    localparam int SUM_W = ((CNT_W > 16) ? CNT_W : 16) + 1;
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] ERR_NO_SOP   = 3'd1;
    localparam logic [2:0] ERR_SOP      = 3'd2;
    localparam logic [2:0] ERR_OVERSIZE = 3'd3;
    localparam logic [2:0] ERR_EMPTY    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  beats_q, beats_d, beats_new;
    logic [LEN_W-1:0]  run_len, fin_len, len_c;
    logic [DATA_W-1:0] xsum_q, xsum_d, xsum_new;
    logic              accept, done_c, err_c;
    logic [2:0]        code_c;
    logic [SUM_W-1:0]  byte_sum;

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        xsum_d    = xsum_q;
        done_c    = 1'b0;
        err_c     = 1'b0;
        code_c    = 3'd0;
        len_c     = '0;
        accept    = in_valid && in_ready;
        beats_new = in_sop ? LEN_W'(1) : beats_q + LEN_W'(1);
        xsum_new  = in_sop ? in_data : (xsum_q ^ in_data);
        run_len   = beats_new * LEN_W'(BPB);
        fin_len   = run_len - LEN_W'(in_empty);

        if (accept) begin
            if (!in_sop && state_q != IN_PKT) begin
                if (state_q == IDLE) begin
                    err_c  = 1'b1;
                    code_c = ERR_NO_SOP;
                end
                state_d = in_eop ? IDLE : DROP;
            end else begin
                // A sop inside an open packet reports that packet first; the
                // code of any fault in the new packet is then not reported.
                if (in_sop && state_q == IN_PKT) begin
                    err_c  = 1'b1;
                    code_c = ERR_SOP;
                end
                beats_d = beats_new;
                xsum_d  = xsum_new;
                if (in_eop) begin
                    state_d = IDLE;
                    if (fin_len > MAX_L) begin
                        code_c = err_c ? code_c : ERR_OVERSIZE;
                        err_c  = 1'b1;
                    end else begin
                        done_c = 1'b1;
                        len_c  = fin_len;
                    end
                end else if (in_empty != '0) begin
                    code_c  = err_c ? code_c : ERR_EMPTY;
                    err_c   = 1'b1;
                    state_d = DROP;
                end else if (run_len > MAX_L) begin
                    code_c  = err_c ? code_c : ERR_OVERSIZE;
                    err_c   = 1'b1;
                    state_d = DROP;
                end else begin
                    state_d = IN_PKT;
                end
            end
        end

        byte_sum = SUM_W'(byte_count) + SUM_W'(len_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beats_q <= '0;
            xsum_q  <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            xsum_q  <= xsum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_err    <= 1'b0;
            err_code   <= 3'd0;
            pkt_len    <= '0;
            pkt_xsum   <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            byte_count <= '0;
        end else begin
            in_ready <= !stall;
            pkt_done <= done_c;
            pkt_err  <= err_c;
            if (done_c) begin
                pkt_len  <= len_c[15:0];
                pkt_xsum <= xsum_d;
                if (pkt_count != CNT_MAX) begin
                    pkt_count <= pkt_count + CNT_W'(1);
                end
                byte_count <= (byte_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : byte_sum[CNT_W-1:0];
            end
            if (err_c) begin
                err_code <= code_c;
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_avst_pkt_sink.sv
// tb/tb_avst_pkt_sink.sv - self-checking bench for avst_pkt_sink
module tb_avst_pkt_sink;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_sop, in_eop, in_valid, stall;
    logic [1:0]  in_empty;
    logic        in_ready, pkt_done, pkt_err;
    logic [15:0] pkt_len;
    logic [31:0] pkt_xsum;
    logic [2:0]  err_code;
    logic [31:0] pkt_count, err_count, byte_count;

    logic        s_ready, s_done, s_err;
    logic [15:0] s_len;
    logic [31:0] s_xsum;
    logic [2:0]  s_code;
    logic [2:0]  s_pcnt, s_ecnt, s_bcnt;

    int n_chk = 0;
    int n_pass = 0;
    int m_pkt = 0;
    int m_err = 0;
    int m_byte = 0;

    typedef struct {
        bit          sop;
        bit          eop;
        logic [1:0]  empty;
        logic [31:0] data;
        bit          e_done;
        bit          e_err;
        logic [2:0]  e_code;
        logic [15:0] e_len;
        logic [31:0] e_xsum;
    } beat_t;

    avst_pkt_sink dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_xsum(pkt_xsum), .pkt_err(pkt_err),
        .err_code(err_code), .pkt_count(pkt_count), .err_count(err_count), .byte_count(byte_count)
    );

    avst_pkt_sink #(.MAX_LEN(8), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_valid(in_valid), .in_ready(s_ready), .stall(stall),
        .pkt_done(s_done), .pkt_len(s_len), .pkt_xsum(s_xsum), .pkt_err(s_err),
        .err_code(s_code), .pkt_count(s_pcnt), .err_count(s_ecnt), .byte_count(s_bcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic beat_t mk(input bit sop, input bit eop, input logic [1:0] empty,
                                 input logic [31:0] data, input bit e_done, input bit e_err,
                                 input logic [2:0] e_code, input logic [15:0] e_len,
                                 input logic [31:0] e_xsum);
        beat_t b;
        b.sop = sop; b.eop = eop; b.empty = empty; b.data = data;
        b.e_done = e_done; b.e_err = e_err; b.e_code = e_code;
        b.e_len = e_len; b.e_xsum = e_xsum;
        return b;
    endfunction

    // Presents one beat until accepted; with rnd set, stall and idle cycles are mixed in.
    task automatic send_beat(input beat_t b, input bit rnd);
        bit acc;
        bit st;
        int guard;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            stall = rnd ? ($urandom_range(3) == 0) : 1'b0;
            st = stall;
            if (rnd && $urandom_range(4) == 0) begin
                in_valid = 1'b0;
                in_sop   = 1'($urandom);
                in_eop   = 1'($urandom);
                in_empty = 2'($urandom);
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_sop   = b.sop;
                in_eop   = b.eop;
                in_empty = b.empty;
                in_data  = b.data;
            end
            acc = in_valid && in_ready;
            cyc();
            chk("in_ready_follows_stall", in_ready, !st);
            if (acc) begin
                if (b.e_done) begin
                    m_pkt++;
                    m_byte += int'(b.e_len);
                end
                if (b.e_err) m_err++;
                chk("pkt_done", pkt_done, b.e_done);
                chk("pkt_err", pkt_err, b.e_err);
                if (b.e_done) begin
                    chk("pkt_len", pkt_len, b.e_len);
                    chk("pkt_xsum", pkt_xsum, b.e_xsum);
                end
                if (b.e_err) chk("err_code", err_code, b.e_code);
                chk("pkt_count", pkt_count, 64'(m_pkt));
                chk("err_count", err_count, 64'(m_err));
                chk("byte_count", byte_count, 64'(m_byte));
            end else begin
                chk("idle_no_done", pkt_done, 0);
                chk("idle_no_err", pkt_err, 0);
            end
            guard++;
        end
        if (!acc) chk("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_pkt_err"}, pkt_err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_pkt_len"}, pkt_len, 0);
        chk({tag, "_pkt_xsum"}, pkt_xsum, 0);
        chk({tag, "_pkt_count"}, pkt_count, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_byte_count"}, byte_count, 0);
    endtask

    beat_t       tbl[15];
    beat_t       b;
    int          n, k, pos;
    logic [1:0]  emp, e_i;
    logic [31:0] d, x, d1, d2, d3;
    bit          pend2;

    initial begin
        tbl[0]  = mk(1, 0, 2'd0, 32'h11111111, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[1]  = mk(0, 0, 2'd0, 32'h22222222, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[2]  = mk(0, 1, 2'd1, 32'h44444444, 1, 0, 3'd0, 16'd11, 32'h77777777);
        tbl[3]  = mk(1, 1, 2'd3, 32'hAABBCCDD, 1, 0, 3'd0, 16'd1, 32'hAABBCCDD);
        tbl[4]  = mk(1, 0, 2'd0, 32'h01020304, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[5]  = mk(1, 1, 2'd0, 32'h10203040, 1, 1, 3'd2, 16'd4, 32'h10203040);
        tbl[6]  = mk(0, 0, 2'd0, 32'h00000005, 0, 1, 3'd1, 16'd0, 32'h0);
        tbl[7]  = mk(0, 1, 2'd0, 32'h00000006, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[8]  = mk(1, 0, 2'd2, 32'h00000007, 0, 1, 3'd4, 16'd0, 32'h0);
        tbl[9]  = mk(0, 1, 2'd0, 32'h00000008, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[10] = mk(1, 0, 2'd0, 32'h00000001, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[11] = mk(0, 1, 2'd2, 32'h00000003, 1, 0, 3'd0, 16'd6, 32'h00000002);
        tbl[12] = mk(1, 0, 2'd0, 32'hF0F0F0F0, 0, 0, 3'd0, 16'd0, 32'h0);
        tbl[13] = mk(1, 0, 2'd0, 32'h0F0F0F0F, 0, 1, 3'd2, 16'd0, 32'h0);
        tbl[14] = mk(0, 1, 2'd0, 32'h00FF00FF, 1, 0, 3'd0, 16'd8, 32'h0FF00FF0);

        reset = 1'b1; stall = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_empty = 2'd0; in_data = 32'h0;
        cyc();
        cyc();
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) send_beat(tbl[i], 1'b0);

        // Oversize on the MAX_LEN=8 instance; the default instance sees a good 16-byte packet.
        x = 32'h0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            x = x ^ d;
            send_beat(mk(i == 0, i == 3, 2'd0, d, i == 3, 0, 3'd0, 16'd16, x), 1'b0);
            chk("ovs_err_pulse", s_err, i == 2);
            if (i == 2) chk("ovs_err_code", s_code, 3);
            if (i == 3) begin
                chk("ovs_no_done", s_done, 0);
                chk("ovs_pkt_count", s_pcnt, 4);
            end
        end

        // Stall held five cycles mid-packet with in_valid kept high.
        d1 = 32'h0A0B0C0D; d2 = 32'h01010101; d3 = 32'h10000000;
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_empty = 2'd0; in_data = d1;
        cyc();
        chk("stall_a_done", pkt_done, 0);
        in_sop = 1'b0; in_data = d2; stall = 1'b1;
        cyc();
        chk("stall_ready_low", in_ready, 0);
        chk("stall_s_ready_low", s_ready, 0);
        in_sop = 1'b1; in_eop = 1'b1; in_data = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_hold_ready", in_ready, 0);
            chk("stall_hold_done", pkt_done, 0);
            chk("stall_hold_err", pkt_err, 0);
        end
        stall = 1'b0;
        cyc();
        chk("stall_release_ready", in_ready, 1);
        chk("stall_release_done", pkt_done, 0);
        chk("stall_release_err", pkt_err, 0);
        in_sop = 1'b0; in_eop = 1'b1; in_data = d3;
        cyc();
        in_valid = 1'b0;
        m_pkt++;
        m_byte += 12;
        chk("stall_done", pkt_done, 1);
        chk("stall_len", pkt_len, 12);
        chk("stall_xsum", pkt_xsum, d1 ^ d2 ^ d3);
        chk("stall_pkt_count", pkt_count, 64'(m_pkt));
        chk("stall_byte_count", byte_count, 64'(m_byte));

        // Randomised packet stream; expectations come from each packet's construction.
        pend2 = 1'b0;
        for (int p = 0; p < 120 || pend2; p++) begin
            k = pend2 ? 0 : $urandom_range(9);
            if (k <= 5) begin
                n = $urandom_range(1, 6);
                emp = 2'($urandom_range(0, 3));
                x = 32'h0;
                for (int i = 0; i < n; i++) begin
                    d = $urandom;
                    x = x ^ d;
                    b = mk(i == 0, i == n - 1, (i == n - 1) ? emp : 2'd0, d, i == n - 1,
                           (i == 0) && pend2, 3'd2, 16'(4 * n - int'(emp)), x);
                    send_beat(b, 1'b1);
                end
                pend2 = 1'b0;
            end else if (k == 6) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++)
                    send_beat(mk(0, i == n - 1, 2'($urandom), $urandom, 0, i == 0, 3'd1, 16'd0, 32'h0), 1'b1);
            end else if (k == 7) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++)
                    send_beat(mk(i == 0, 0, 2'd0, $urandom, 0, 0, 3'd0, 16'd0, 32'h0), 1'b1);
                pend2 = 1'b1;
            end else begin
                n = $urandom_range(2, 5);
                pos = $urandom_range(0, n - 2);
                for (int i = 0; i < n; i++) begin
                    e_i = (i == pos) ? 2'($urandom_range(1, 3)) : ((i == n - 1) ? 2'($urandom) : 2'd0);
                    send_beat(mk(i == 0, i == n - 1, e_i, $urandom, 0, i == pos, 3'd4, 16'd0, 32'h0), 1'b1);
                end
            end
        end

        chk("sat_pkt_count", s_pcnt, 7);
        chk("sat_err_count", s_ecnt, 7);
        chk("sat_byte_count", s_bcnt, 7);

        // Reset while a packet is open, then a beat without sop.
        send_beat(mk(1, 0, 2'd0, 32'hCAFEF00D, 0, 0, 3'd0, 16'd0, 32'h0), 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        cyc();
        chk_zero("midrst");
        reset = 1'b0;
        m_pkt = 0; m_err = 0; m_byte = 0;
        cyc();
        chk("post_reset_ready", in_ready, 1);
        send_beat(mk(0, 1, 2'd0, 32'h12345678, 0, 1, 3'd1, 16'd0, 32'h0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/avst_pkt_sink.md
AVST_PKT_SINK -- requirements
Module: avst_pkt_sink

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 32, beat width in bits (multiple of 8)
- EMPTY_W, 2, width of in_empty, equal to log2(DATA_W/8)
- MAX_LEN, 1518, largest legal packet length in bytes
- CNT_W, 32, statistics counter width

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_W  Avalon-ST data; byte 0 in [DATA_W-1:DATA_W-8]
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_empty  in  EMPTY_W  count of unused bytes; meaningful only on an eop beat
- in_valid  in  1  beat valid
- in_ready  out  1  sink ready
- stall  in  1  backpressure request
- pkt_done  out  1  one-cycle pulse: a good packet has completed
- pkt_len  out  16  byte length of the completed packet
- pkt_xsum  out  DATA_W  XOR of all data beats of the completed packet
- pkt_err  out  1  one-cycle pulse: a framing error was detected
- err_code  out  3  1 = missing sop, 2 = unexpected sop, 3 = oversize, 4 = bad empty
- pkt_count  out  CNT_W  good packets received
- err_count  out  CNT_W  errors detected
- byte_count  out  CNT_W  bytes received in good packets

Function
REQ-003 A beat SHALL be accepted only in a cycle where in_valid && in_ready; all other input cycles SHALL be ignored.
REQ-004 in_ready SHALL be a registered copy of !stall, so it changes one cycle after stall changes.
REQ-005 The FSM SHALL have exactly three states: IDLE, IN_PKT and DROP.
REQ-006 IDLE:
- sop && eop beat: completes a single-beat packet; stay in IDLE.
- sop && !eop beat: go to IN_PKT.
- !sop beat: error code 1; go to DROP if !eop, else stay in IDLE.
REQ-007 IN_PKT:
- eop beat: completes the packet; go to IDLE.
- sop beat: error code 2 for the open packet, which is discarded; the beat then starts a new packet, following the IDLE rules for a sop beat.
REQ-008 DROP:
- discard beats without sop.
- a !sop && eop beat returns the FSM to IDLE with no further error.
- a sop beat is handled as in IDLE.
REQ-009 The beat counter SHALL count accepted beats of the open packet. The running length SHALL be beats*(DATA_W/8), and on the eop beat it SHALL be reduced by in_empty.
REQ-010 If the running length exceeds MAX_LEN before eop, the block SHALL raise error code 3 once and go to DROP.
REQ-011 A non-zero in_empty on a non-eop beat within a packet SHALL raise error code 4 and send the FSM to DROP.
REQ-012 pkt_xsum SHALL be the XOR of every data beat of the packet, with empty bytes included as received.
REQ-013 On a good packet completion, the cycle after the eop beat is accepted:
- pkt_done SHALL pulse for one cycle.
- pkt_len and pkt_xsum SHALL be updated and held until the next completion.
- pkt_count SHALL increment by 1.
- byte_count SHALL increment by pkt_len.
REQ-014 On an error, the cycle after the offending beat:
- pkt_err SHALL pulse for one cycle.
- err_code SHALL be updated and held until the next error.
- err_count SHALL increment by 1.
REQ-015 When one beat both ends a good packet and reveals an error, such as a sop && eop beat arriving in IN_PKT, pkt_err and pkt_done SHALL pulse in the same cycle.
REQ-016 All counters SHALL saturate at all-ones and never wrap.
REQ-017 Errored packets SHALL contribute nothing to pkt_count, byte_count, pkt_len or pkt_xsum.

Reset
REQ-018 While reset is high at a rising edge, the block SHALL load these values:
- FSM to IDLE
- in_ready = 0
- pkt_done = 0, pkt_err = 0
- err_code = 0, pkt_len = 0, pkt_xsum = 0
- all counters = 0
- the open packet is discarded with no error
REQ-019 in_ready SHALL follow !stall from the first cycle after reset deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Three beats (sop; -; eop with empty=1), data 0x11111111, 0x22222222, 0x44444444 -> pkt_done, pkt_len=11, pkt_xsum=0x77777777, pkt_count=1, byte_count=11.
- Single beat sop && eop, empty=3 -> pkt_len=1, stays in IDLE.
- sop, sop+eop, empty=0 -> pkt_err with err_code=2 and pkt_done with pkt_len=4 in the same cycle; pkt_count=1, err_count=1.
- Beat without sop in IDLE, then eop -> one pkt_err with err_code=1 and no pkt_done.
- MAX_LEN=8, four beats of 4 bytes -> err_code=3 after beat 3, trailing eop silently dropped, pkt_count unchanged.
- stall held high for 5 cycles mid-packet with in_valid=1 -> in_ready low from the cycle after stall rises, no beats counted, packet completes correctly afterwards.
- reset asserted mid-packet -> all outputs 0; a following beat without sop gives err_code=1.
